// File: rtl/pingpong_pkg.sv
// Shared types and helpers for the ping-pong buffer controller.
package pingpong_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } bank_state_t;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    // A bank can take producer words until its frame is complete.
    function automatic logic is_writable(input bank_state_t s);
        return (s == EMPTY) || (s == FILL);
    endfunction

    function automatic logic is_readable(input bank_state_t s);
        return (s == FULL) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/pingpong_buf_ctrl_out_skid.sv
// Two-entry skid FIFO catching RAM read data; entry 0 is always the head,
// so the head word holds still while the consumer stalls.
module out_skid
    import pingpong_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic         pop_s, push_s;

    assign pop_s  = pop & (cnt_q != 2'd0);
    assign push_s = push & ((cnt_q != 2'd2) | pop_s);

    // Next entry contents and occupancy.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    e0_d = push_data;
                end else begin
                    e1_d = push_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end else begin
                    e0_d = push_data;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        valid_d = (cnt_d != 2'd0);
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign head  = e0_q;
    assign valid = valid_q;
    assign count = cnt_q;

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong frame buffer controller: the producer fills one RAM bank while the
// consumer drains the other, and the roles swap at every frame boundary.
module pingpong_buf_ctrl
    import pingpong_pkg::*;
#(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int FRAME = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          ram_ce,
    output logic          ram_we_a,
    output logic          ram_we_b,
    output logic [AW-1:0] ram_adr_a,
    output logic [AW-1:0] ram_adr_b,
    output logic [DW-1:0] ram_din_a,
    output logic [DW-1:0] ram_din_b,
    input  logic [DW-1:0] ram_dout_a,
    input  logic [DW-1:0] ram_dout_b
);

    localparam logic [AW-1:0] LAST_ADR = AW'(FRAME - 1);

    bank_state_t   state_q [2];
    bank_state_t   state_d [2];
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          infl_q, infl_d;
    logic          infl_last_q, infl_last_d;
    logic          infl_bank_q, infl_bank_d;
    logic          ram_ce_q;

    logic          accept_s, issue_s, rd_owned_s, pop_s;
    logic [1:0]    skid_cnt_s, pending_s;
    logic          skid_valid_s;
    logic [DW:0]   skid_head_s;
    logic [DW:0]   skid_push_data_s;

    assign in_ready   = ~rst & is_writable(state_q[wr_bank_q]);
    assign accept_s   = in_valid & in_ready;
    assign rd_owned_s = is_readable(state_q[rd_bank_q]);
    assign pop_s      = skid_valid_s & out_ready;

    // Occupancy is taken after this cycle's pop so a draining consumer sees
    // one read per cycle; the skid never has to hold more than two words.
    assign pending_s  = skid_cnt_s - {1'b0, pop_s} + {1'b0, infl_q};
    assign issue_s    = rd_owned_s & (pending_s < 2'd2);

    // Writer and reader bookkeeping; they never touch the same bank at once.
    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        infl_bank_d = infl_bank_q;

        if (accept_s) begin
            if (wr_ptr_q == LAST_ADR) begin
                state_d[wr_bank_q] = FULL;
                wr_ptr_d           = '0;
                wr_bank_d          = ~wr_bank_q;
            end else begin
                state_d[wr_bank_q] = FILL;
                wr_ptr_d           = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (issue_s) begin
            infl_d      = 1'b1;
            infl_bank_d = rd_bank_q;
            infl_last_d = (rd_ptr_q == LAST_ADR);
            if (rd_ptr_q == LAST_ADR) begin
                state_d[rd_bank_q] = EMPTY;
                rd_ptr_d           = '0;
                rd_bank_d          = ~rd_bank_q;
            end else begin
                state_d[rd_bank_q] = DRAIN;
                rd_ptr_d           = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Bank state, ownership and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0]  <= EMPTY;
            state_q[1]  <= EMPTY;
            wr_bank_q   <= BANK_A;
            rd_bank_q   <= BANK_A;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            infl_bank_q <= BANK_A;
            ram_ce_q    <= 1'b0;
        end else begin
            state_q[0]  <= state_d[0];
            state_q[1]  <= state_d[1];
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            infl_bank_q <= infl_bank_d;
            ram_ce_q    <= 1'b1;
        end
    end

    // Bank A port: writer, reader, or parked at zero.
    always_comb begin
        ram_we_a  = 1'b0;
        ram_adr_a = '0;
        ram_din_a = '0;
        if (accept_s && (wr_bank_q == BANK_A)) begin
            ram_we_a  = 1'b1;
            ram_adr_a = wr_ptr_q;
            ram_din_a = in_data;
        end else if (rd_owned_s && (rd_bank_q == BANK_A)) begin
            ram_adr_a = rd_ptr_q;
        end else begin
            ram_adr_a = '0;
        end
    end

    // Bank B port: writer, reader, or parked at zero.
    always_comb begin
        ram_we_b  = 1'b0;
        ram_adr_b = '0;
        ram_din_b = '0;
        if (accept_s && (wr_bank_q == BANK_B)) begin
            ram_we_b  = 1'b1;
            ram_adr_b = wr_ptr_q;
            ram_din_b = in_data;
        end else if (rd_owned_s && (rd_bank_q == BANK_B)) begin
            ram_adr_b = rd_ptr_q;
        end else begin
            ram_adr_b = '0;
        end
    end

    assign skid_push_data_s = {infl_last_q, (infl_bank_q == BANK_B) ? ram_dout_b : ram_dout_a};

    out_skid #(
        .W (DW + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (infl_q),
        .push_data (skid_push_data_s),
        .pop       (pop_s),
        .head      (skid_head_s),
        .valid     (skid_valid_s),
        .count     (skid_cnt_s)
    );

    assign ram_ce    = ram_ce_q;
    assign out_valid = skid_valid_s;
    assign out_data  = skid_head_s[DW-1:0];
    assign out_last  = skid_valid_s & skid_head_s[DW];

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Directed bench for pingpong_buf_ctrl with FRAME=4: a frame-level model of
// where each accepted word must land and the order words must leave.
module tb_pingpong_buf_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int FRAME = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          ram_ce, ram_we_a, ram_we_b;
    logic [AW-1:0] ram_adr_a, ram_adr_b;
    logic [DW-1:0] ram_din_a, ram_din_b;
    logic [DW-1:0] ram_dout_a, ram_dout_b;

    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_out = 0;
    int first_out = -1;
    int last_out = -1;
    int n_stall = 0;
    int stall_total = 0;
    logic [DW:0] exp_q [$];
    logic [DW:0] held;
    logic [DW:0] last_word;
    logic        stall_v = 1'b0;
    logic [3:0]  pat = 4'b1001;

    pingpong_buf_ctrl #(.DW(DW), .AW(AW), .FRAME(FRAME)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .ram_ce     (ram_ce),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .ram_adr_a  (ram_adr_a),
        .ram_adr_b  (ram_adr_b),
        .ram_din_a  (ram_din_a),
        .ram_din_b  (ram_din_b),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b)
    );

    always #5 clk = ~clk;

    // Two independent single-port banks with registered read.
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we_a) mem_a[ram_adr_a] <= ram_din_a;
            if (ram_we_b) mem_b[ram_adr_b] <= ram_din_b;
            ram_dout_a <= mem_a[ram_adr_a];
            ram_dout_b <= mem_b[ram_adr_b];
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: word n goes to bank (n/FRAME)%2 at address n%FRAME and leaves in
    // arrival order, tagged last on every FRAME-th word.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            n_acc   = 0;
            stall_v = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                if (((n_acc / FRAME) % 2) == 0) begin
                    chk("wr_we_a", ram_we_a, 1);
                    chk("wr_adr_a", ram_adr_a, n_acc % FRAME);
                    chk("wr_din_a", ram_din_a, in_data);
                    chk("wr_we_b_idle", ram_we_b, 0);
                end else begin
                    chk("wr_we_b", ram_we_b, 1);
                    chk("wr_adr_b", ram_adr_b, n_acc % FRAME);
                    chk("wr_din_b", ram_din_b, in_data);
                    chk("wr_we_a_idle", ram_we_a, 0);
                end
                exp_q.push_back({((n_acc % FRAME) == FRAME - 1), in_data});
                n_acc++;
            end else begin
                chk("no_write", {ram_we_a, ram_we_b}, 0);
            end

            if (stall_v) begin
                n_stall++;
                chk("stall_valid", out_valid, 1);
                chk("stall_word", {out_last, out_data}, held);
            end
            if (!out_valid) chk("last_idle", out_last, 0);

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_extra: got %0h, expected no word (cycle %0d)", {out_last, out_data}, cyc);
                end else begin
                    chk("out_word", {out_last, out_data}, exp_q.pop_front());
                end
                last_word = {out_last, out_data};
                n_out++;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            stall_v = out_valid && !out_ready;
            held    = {out_last, out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 200) begin
            tick();
            guard++;
            stall_total++;
        end
        if (guard >= 200) chk("send_timeout", guard, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || out_valid); i++) tick();
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_valid", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and release.
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ram_ce", ram_ce, 0);
        chk("rst_we", {ram_we_a, ram_we_b}, 0);
        chk("rst_adr", {ram_adr_a, ram_adr_b}, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_ram_ce_pre", ram_ce, 0);
        tick();
        chk("rel_ram_ce", ram_ce, 1);
        chk("rel_out_valid", out_valid, 0);
        chk("rel_we", {ram_we_a, ram_we_b}, 0);

        // Single frame and first-word latency.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
        chk("lat_t0", out_valid, 0);
        tick();
        chk("lat_t1", out_valid, 0);
        tick();
        chk("lat_t2", out_valid, 1);
        chk("lat_data", out_data, 8'h10);
        wait_drain();
        chk("frame1_last", last_word, 9'h113);

        // Three back-to-back frames with no bubbles.
        do_reset();
        out_ready   = 1'b1;
        first_out   = -1;
        n_out       = 0;
        stall_total = 0;
        for (int i = 0; i < 12; i++) send(8'h20 + 8'(i));
        wait_drain();
        chk("stream_count", n_out, 12);
        chk("stream_span", last_out - first_out, 11);
        chk("stream_in_stall", stall_total, 0);
        chk("stream_last", last_word, 9'h12B);

        // Consumer back-pressure pattern 1,0,0,1.
        do_reset();
        n_stall = 0;
        n_out   = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
            end
            begin
                for (int i = 0; i < 48; i++) begin
                    out_ready = pat[i % 4];
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        chk("bp_count", n_out, 8);
        chk("bp_stalled", (n_stall > 0), 1);

        // Both banks full, then release.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'h40 + 8'(i));
        chk("full_in_ready", in_ready, 0);
        chk("full_head", out_data, 8'h40);
        out_ready = 1'b1;
        chk("rel_c0", in_ready, 0);
        tick();
        chk("rel_c1", in_ready, 0);
        tick();
        chk("rel_c2", in_ready, 1);
        wait_drain();

        // Reset mid-frame with a word waiting at the output.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h40 + 8'(i));
        tick();
        tick();
        tick();
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 8'h40);
        send(8'h50);
        send(8'h51);
        in_valid = 1'b1;
        in_data  = 8'h52;
        rst      = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out", {out_valid, out_last, out_data}, 0);
        chk("mid_rst_ce", ram_ce, 0);
        chk("mid_rst_we", {ram_we_a, ram_we_b}, 0);
        chk("mid_rst_adr", {ram_adr_a, ram_adr_b}, 0);
        chk("mid_rst_din", {ram_din_a, ram_din_b}, 0);
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h60;
        #1;
        chk("post_rst_we_a", ram_we_a, 1);
        chk("post_rst_adr_a", ram_adr_a, 0);
        chk("post_rst_din_a", ram_din_a, 8'h60);
        tick();
        for (int i = 1; i < 4; i++) send(8'h60 + 8'(i));
        out_ready = 1'b1;
        wait_drain();
        chk("post_rst_last", last_word, 9'h163);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
